// File: rtl/lcd_hd44780_ctrl.sv
// Write-only HD44780 character LCD controller on an 8-bit bus: power-up wait, fixed
// init sequence, then host command/data writes through a valid/ready handshake.
module lcd_hd44780_ctrl #(
  parameter int         CNT_W          = 20,
  parameter int         POWERUP_CYCLES = 750000,
  parameter int         SETUP_CYCLES   = 4,
  parameter int         E_CYCLES       = 262144,
  parameter int         INTER_CYCLES   = 2600,
  parameter int         LONG_CYCLES    = 82000,
  parameter logic [7:0] FUNC_SET       = 8'h3C,
  parameter logic [7:0] ENTRY_MODE     = 8'h06,
  parameter logic [7:0] DISP_CTRL      = 8'h0C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  typedef enum logic [2:0] {S_POWERUP, S_SETUP, S_PULSE, S_HOLD, S_IDLE} state_t;

  // Each state lasts N cycles: the counter is loaded with N-1 and the state exits on 0.
  localparam logic [CNT_W-1:0] POWERUP_LOAD = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] E_LOAD       = CNT_W'(E_CYCLES - 1);
  localparam logic [CNT_W-1:0] INTER_LOAD   = CNT_W'(INTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LOAD    = CNT_W'(LONG_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic             e_reg, e_next;
  logic             rs_reg, rs_next;
  logic [7:0]       data_reg, data_next;
  logic             ready_reg, ready_next;
  logic             done_reg, done_next;

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2, 3'd3: init_byte = FUNC_SET;
      3'd4:                   init_byte = 8'h08;
      3'd5:                   init_byte = 8'h01;
      3'd6:                   init_byte = ENTRY_MODE;
      3'd7:                   init_byte = DISP_CTRL;
      default:                init_byte = 8'h00;
    endcase
  endfunction

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  function automatic logic is_long(input logic rs, input logic [7:0] b);
    is_long = !rs && (b[7:2] == 6'd0) && (b[1:0] != 2'd0);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_POWERUP;
      cnt_reg   <= POWERUP_LOAD;
      idx_reg   <= 3'd0;
      e_reg     <= 1'b0;
      rs_reg    <= 1'b0;
      data_reg  <= 8'h00;
      ready_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      e_reg     <= e_next;
      rs_reg    <= rs_next;
      data_reg  <= data_next;
      ready_reg <= ready_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg - CNT_W'(1);
    idx_next   = idx_reg;
    e_next     = e_reg;
    rs_next    = rs_reg;
    data_next  = data_reg;
    ready_next = ready_reg;
    done_next  = done_reg;
    case (state_reg)
      S_POWERUP: if (cnt_reg == '0) begin
        state_next = S_SETUP;
        cnt_next   = SETUP_LOAD;
        rs_next    = 1'b0;
        data_next  = init_byte(3'd0);
      end
      S_SETUP: if (cnt_reg == '0) begin
        state_next = S_PULSE;
        cnt_next   = E_LOAD;
        e_next     = 1'b1;
      end
      S_PULSE: if (cnt_reg == '0) begin
        state_next = S_HOLD;
        cnt_next   = is_long(rs_reg, data_reg) ? LONG_LOAD : INTER_LOAD;
        e_next     = 1'b0;
      end
      S_HOLD: if (cnt_reg == '0) begin
        if (!done_reg && idx_reg != 3'd7) begin
          state_next = S_SETUP;
          cnt_next   = SETUP_LOAD;
          idx_next   = idx_reg + 3'd1;
          rs_next    = 1'b0;
          data_next  = init_byte(idx_reg + 3'd1);
        end else begin
          state_next = S_IDLE;
          ready_next = 1'b1;
          done_next  = 1'b1;
        end
      end
      S_IDLE: begin
        cnt_next = cnt_reg;
        if (wr_valid) begin
          state_next = S_SETUP;
          cnt_next   = SETUP_LOAD;
          rs_next    = wr_rs;
          data_next  = wr_data;
          ready_next = 1'b0;
        end
      end
      default: begin
        state_next = S_POWERUP;
        cnt_next   = POWERUP_LOAD;
      end
    endcase
  end

  assign wr_ready  = ready_reg;
  assign init_done = done_reg;
  assign lcd_e     = e_reg;
  assign lcd_rs    = rs_reg;
  assign lcd_data  = data_reg;
  assign lcd_rw    = 1'b0;

endmodule
